// File: rtl/unix_to_calendar_conv.sv
// rtl/unix_to_calendar_conv.sv - iterative Unix timestamp to Gregorian date/time/weekday converter
// Optional feature macro: UNIX_CONV_TZ_EN (applies tz_offset_min when defined)
module unix_to_calendar_conv #(
    parameter int TIME_W = 64,
    parameter int YEAR_W = 14
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [TIME_W-1:0]        unix_time,
    input  logic signed [11:0]       tz_offset_min,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [YEAR_W-1:0]        year,
    output logic [3:0]               month,
    output logic [4:0]               day,
    output logic [2:0]               weekday,
    output logic [4:0]               hour,
    output logic [5:0]               minute,
    output logic [5:0]               second
);

    localparam int AW  = TIME_W + 2;
    localparam int YW1 = YEAR_W + 1;

    // Seconds from 0001-01-01 to 1970-01-01, and the block sizes peeled off in turn
    localparam logic [AW-1:0] EPOCH = AW'(64'd62135596800);
    localparam logic [AW-1:0] S400  = AW'(64'd12622780800);
    localparam logic [AW-1:0] S100  = AW'(64'd3155673600);
    localparam logic [AW-1:0] S4    = AW'(64'd126230400);
    localparam logic [AW-1:0] S1    = AW'(64'd31536000);
    localparam logic [AW-1:0] SDAY  = AW'(64'd86400);
    localparam logic [AW-1:0] SHR   = AW'(64'd3600);
    localparam logic [AW-1:0] SMIN  = AW'(64'd60);

    // Year is kept one bit wider so overshoot past the output range is detectable
    localparam logic [YW1-1:0] YMAX = {1'b0, {YEAR_W{1'b1}}};

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_Y400, S_Y100, S_Y4, S_Y1,
        S_LEAP, S_DAYS, S_HOURS, S_MINS, S_DONE
    } state_t;

    state_t state, state_next;

    logic [TIME_W-1:0] t_reg;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     acc_load;
    logic [YW1-1:0]    yr;
    logic [YW1-1:0]    yr_p400;
    logic [2:0]        wd;
    logic [1:0]        t100;
    logic [4:0]        t4;
    logic [1:0]        t1;
    logic [3:0]        mon_idx;
    logic [4:0]        dcnt;
    logic [4:0]        hr;
    logic [5:0]        mi;
    logic              feb29;
    logic              err_pend;
    logic [4:0]        mon_len;

    logic ge_400, ge_100, ge_4, ge_1, ge_day, ge_hr, ge_min;
    logic load_neg, y400_ovf, yr_ovf, month_end;

`ifdef UNIX_CONV_TZ_EN
    logic signed [11:0]   tz_reg;
    logic signed [AW-1:0] tz_ext;
    logic [AW-1:0]        tz_sec;

    // 60*tz as (64-4)*tz keeps the offset path to shifts and one subtractor
    assign tz_ext   = AW'(tz_reg);
    assign tz_sec   = (tz_ext <<< 6) - (tz_ext <<< 2);
    assign acc_load = {2'b00, t_reg} + EPOCH + tz_sec;
`else
    logic tz_unused;

    // Offset port is kept for pin compatibility but has no effect in this build
    assign tz_unused = ^tz_offset_min;
    assign acc_load  = {2'b00, t_reg} + EPOCH;
`endif

    assign load_neg  = acc_load[AW-1];
    assign yr_p400   = yr + YW1'(400);
    assign y400_ovf  = (yr_p400 > YMAX);
    assign yr_ovf    = (yr > YMAX);
    assign ge_400    = (acc >= S400);
    assign ge_100    = (acc >= S100) && (t100 != 2'd3);
    assign ge_4      = (acc >= S4);
    assign ge_1      = (acc >= S1) && (t1 != 2'd3);
    assign ge_day    = (acc >= SDAY);
    assign ge_hr     = (acc >= SHR);
    assign ge_min    = (acc >= SMIN);
    assign month_end = ((dcnt + 5'd1) == mon_len);
    assign busy      = (state != S_IDLE);

    // Advance weekday by k modulo 7
    function automatic logic [2:0] wd_add(input logic [2:0] w, input logic [2:0] k);
        logic [3:0] s;
        s = {1'b0, w} + {1'b0, k};
        if (s >= 4'd7) s = s - 4'd7;
        return s[2:0];
    endfunction

    // Length of the current month, February depending on the leap decision
    always_comb begin
        mon_len = 5'd31;
        case (mon_idx)
            4'd1:                      mon_len = feb29 ? 5'd29 : 5'd28;
            4'd3, 4'd5, 4'd8, 4'd10:   mon_len = 5'd30;
            default:                   mon_len = 5'd31;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state: each iterative state stays while another block can be subtracted
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD:  state_next = load_neg ? S_DONE : S_Y400;
            S_Y400:  if (ge_400) state_next = y400_ovf ? S_DONE : S_Y400;
                     else        state_next = S_Y100;
            S_Y100:  if (!ge_100) state_next = S_Y4;
            S_Y4:    if (!ge_4)   state_next = S_Y1;
            S_Y1:    if (!ge_1)   state_next = S_LEAP;
            S_LEAP:  state_next = yr_ovf ? S_DONE : S_DAYS;
            S_DAYS:  if (!ge_day) state_next = S_HOURS;
            S_HOURS: if (!ge_hr)  state_next = S_MINS;
            S_MINS:  if (!ge_min) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: one subtraction per cycle, results committed on the completion edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_reg    <= '0;
            acc      <= '0;
            yr       <= YW1'(1);
            wd       <= 3'd1;
            t100     <= '0;
            t4       <= '0;
            t1       <= '0;
            mon_idx  <= '0;
            dcnt     <= '0;
            hr       <= '0;
            mi       <= '0;
            feb29    <= 1'b0;
            err_pend <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            year     <= YEAR_W'(1970);
            month    <= 4'd1;
            day      <= 5'd1;
            weekday  <= 3'd4;
            hour     <= '0;
            minute   <= '0;
            second   <= '0;
`ifdef UNIX_CONV_TZ_EN
            tz_reg   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        t_reg    <= unix_time;
`ifdef UNIX_CONV_TZ_EN
                        tz_reg   <= tz_offset_min;
`endif
                        yr       <= YW1'(1);
                        wd       <= 3'd1;
                        t100     <= '0;
                        t4       <= '0;
                        t1       <= '0;
                        mon_idx  <= '0;
                        dcnt     <= '0;
                        hr       <= '0;
                        mi       <= '0;
                        err_pend <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                S_LOAD: begin
                    acc <= acc_load;
                    if (load_neg) err_pend <= 1'b1;
                end
                S_Y400: begin
                    if (ge_400) begin
                        if (y400_ovf) begin
                            err_pend <= 1'b1;
                        end else begin
                            acc <= acc - S400;
                            yr  <= yr_p400;
                        end
                    end
                end
                S_Y100: begin
                    if (ge_100) begin
                        acc  <= acc - S100;
                        yr   <= yr + YW1'(100);
                        t100 <= t100 + 2'd1;
                        wd   <= wd_add(wd, 3'd5);
                    end
                end
                S_Y4: begin
                    if (ge_4) begin
                        acc <= acc - S4;
                        yr  <= yr + YW1'(4);
                        t4  <= t4 + 5'd1;
                        wd  <= wd_add(wd, 3'd5);
                    end
                end
                S_Y1: begin
                    if (ge_1) begin
                        acc <= acc - S1;
                        yr  <= yr + YW1'(1);
                        t1  <= t1 + 2'd1;
                        wd  <= wd_add(wd, 3'd1);
                    end
                end
                S_LEAP: begin
                    feb29 <= (t1 == 2'd3) && ((t4 != 5'd24) || (t100 == 2'd3));
                    if (yr_ovf) err_pend <= 1'b1;
                end
                S_DAYS: begin
                    if (ge_day) begin
                        acc <= acc - SDAY;
                        wd  <= wd_add(wd, 3'd1);
                        if (month_end) begin
                            dcnt    <= '0;
                            mon_idx <= mon_idx + 4'd1;
                        end else begin
                            dcnt <= dcnt + 5'd1;
                        end
                    end
                end
                S_HOURS: begin
                    if (ge_hr) begin
                        acc <= acc - SHR;
                        hr  <= hr + 5'd1;
                    end
                end
                S_MINS: begin
                    if (ge_min) begin
                        acc <= acc - SMIN;
                        mi  <= mi + 6'd1;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    err  <= err_pend;
                    if (!err_pend) begin
                        year    <= yr[YEAR_W-1:0];
                        month   <= mon_idx + 4'd1;
                        day     <= dcnt + 5'd1;
                        weekday <= wd;
                        hour    <= hr;
                        minute  <= mi;
                        second  <= acc[5:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unix_to_calendar_conv.sv
// tb/tb_unix_to_calendar_conv.sv - directed self-checking bench for unix_to_calendar_conv
module tb_unix_to_calendar_conv;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [63:0]        unix_time;
    logic signed [11:0] tz_offset_min;
    logic               busy;
    logic               done;
    logic               err;
    logic [13:0]        year;
    logic [3:0]         month;
    logic [4:0]         day;
    logic [2:0]         weekday;
    logic [4:0]         hour;
    logic [5:0]         minute;
    logic [5:0]         second;

    int n_checks;
    int n_pass;

    unix_to_calendar_conv #(.TIME_W(64), .YEAR_W(14)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .unix_time     (unix_time),
        .tz_offset_min (tz_offset_min),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .year          (year),
        .month         (month),
        .day           (day),
        .weekday       (weekday),
        .hour          (hour),
        .minute        (minute),
        .second        (second)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_dt(input string tag, input int y, input int mo, input int d,
                            input int w, input int h, input int mi, input int s, input int e);
        check({tag, "_year"},  64'(year),    64'(y));
        check({tag, "_month"}, 64'(month),   64'(mo));
        check({tag, "_day"},   64'(day),     64'(d));
        check({tag, "_wday"},  64'(weekday), 64'(w));
        check({tag, "_hour"},  64'(hour),    64'(h));
        check({tag, "_min"},   64'(minute),  64'(mi));
        check({tag, "_sec"},   64'(second),  64'(s));
        check({tag, "_err"},   64'(err),     64'(e));
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic run_conv(input string tag, input logic [63:0] t, input logic signed [11:0] tz);
        @(negedge clk);
        start = 1'b1;
        unix_time = t;
        tz_offset_min = tz;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_hi"}, 64'(busy), 64'd1);
        wait_done(tag);
    endtask

    task automatic check_one_pulse(input string tag);
        @(negedge clk);
        check({tag, "_done_lo"}, 64'(done), 64'd0);
        check({tag, "_busy_lo"}, 64'(busy), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b0;
        start = 1'b0;
        unix_time = '0;
        tz_offset_min = '0;
        repeat (3) @(negedge clk);
        check_dt("reset", 1970, 1, 1, 4, 0, 0, 0, 0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_conv("epoch", 64'd0, 12'sd0);
        check_dt("epoch", 1970, 1, 1, 4, 0, 0, 0, 0);
        check_one_pulse("epoch");

        run_conv("y2000", 64'd951782400, 12'sd0);
        check_dt("y2000", 2000, 2, 29, 2, 0, 0, 0, 0);
        check_one_pulse("y2000");

        run_conv("y2100a", 64'd4107542399, 12'sd0);
        check_dt("y2100a", 2100, 2, 28, 0, 23, 59, 59, 0);

        run_conv("y2100b", 64'd4107542400, 12'sd0);
        check_dt("y2100b", 2100, 3, 1, 1, 0, 0, 0, 0);

        run_conv("tz480", 64'd1700000000, 12'sd480);
`ifdef UNIX_CONV_TZ_EN
        check_dt("tz480", 2023, 11, 15, 3, 6, 13, 20, 0);
        run_conv("tzm60", 64'd0, -12'sd60);
        check_dt("tzm60", 1969, 12, 31, 3, 23, 0, 0, 0);
`else
        check_dt("tz480", 2023, 11, 14, 2, 22, 13, 20, 0);
`endif

        run_conv("y2100c", 64'd4107542400, 12'sd0);
        run_conv("range", 64'hFFFF_FFFF_FFFF_FFFF, 12'sd0);
        check_dt("range", 2100, 3, 1, 1, 0, 0, 0, 1);
        check_one_pulse("range");
        run_conv("recover", 64'd0, 12'sd0);
        check_dt("recover", 1970, 1, 1, 4, 0, 0, 0, 0);

        @(negedge clk);
        start = 1'b1;
        unix_time = 64'd951782400;
        tz_offset_min = 12'sd0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        unix_time = 64'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore");
        check_dt("ignore", 2000, 2, 29, 2, 0, 0, 0, 0);
        check_one_pulse("ignore");

        run_conv("pre_rst", 64'd4107542399, 12'sd0);
        @(negedge clk);
        start = 1'b1;
        unix_time = 64'd1700000000;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_dt("abort", 1970, 1, 1, 4, 0, 0, 0, 0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_conv("post_rst", 64'd4107542400, 12'sd0);
        check_dt("post_rst", 2100, 3, 1, 1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
